// File: rtl/pipe3_core.sv
// pipe3_core: three-stage (IF, EX, MEM/WB) pipelined core for the 16-bit,
// 4-bit-opcode ISA. It provides EX-stage forwarding from MEM/WB, a one-slot
// squash on taken branches, a data-memory stall handshake and a HALT sequence.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   imem_addr/data     fetch address (= PC) and combinational instruction word
//   dmem_req/we        MEM/WB holds a valid LW/SW; we=1 for a store
//   dmem_addr/wdata    effective address and store data
//   dmem_rdata/ready   load data; the access completes in a cycle with ready=1
//   halted             HALT has retired; the core stays frozen until rst
//   retire             one pulse per instruction leaving MEM/WB
//   pc                 current fetch PC
module pipe3_core #(
    parameter int unsigned DSIZE = 16,
    parameter int unsigned ASIZE = 4,
    parameter int unsigned ISIZE = 16,
    parameter int unsigned IMMW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ISIZE-1:0] imem_addr,
    input  logic [15:0]      imem_data,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DSIZE-1:0] dmem_addr,
    output logic [DSIZE-1:0] dmem_wdata,
    input  logic [DSIZE-1:0] dmem_rdata,
    input  logic             dmem_ready,
    output logic             halted,
    output logic             retire,
    output logic [ISIZE-1:0] pc
);
    localparam int unsigned NREG = 2 ** ASIZE;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HALTING = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;

    // IF/ID register
    logic             ifid_valid;
    logic [15:0]      ifid_instr;
    logic [ISIZE-1:0] ifid_pc;

    // MEM/WB register; mw_wr already folds in valid and rd != 0
    logic             mw_valid;
    logic             mw_wr;
    logic [3:0]       mw_op;
    logic [ASIZE-1:0] mw_rd;
    logic [DSIZE-1:0] mw_result;
    logic [DSIZE-1:0] mw_wdata;

    logic [DSIZE-1:0] regs [NREG];

    logic             stall;
    logic [DSIZE-1:0] wb_val;

    // EX-stage decode and execute
    logic [3:0]       ex_op;
    logic [ASIZE-1:0] ex_rd;
    logic [ASIZE-1:0] ex_rs;
    logic [ASIZE-1:0] ex_rt;
    logic [IMMW-1:0]  ex_imm;
    logic [DSIZE-1:0] ex_imm_d;
    logic [DSIZE-1:0] val_rd;
    logic [DSIZE-1:0] val_rs;
    logic [DSIZE-1:0] val_rt;
    logic [DSIZE-1:0] ex_result;
    logic             ex_wr;
    logic             ex_taken;
    logic             ex_halt;
    logic [ISIZE-1:0] br_target;

    assign imem_addr  = pc;
    assign dmem_req   = mw_valid && (mw_op == OP_LW || mw_op == OP_SW);
    assign dmem_we    = mw_valid && (mw_op == OP_SW);
    assign dmem_addr  = mw_result;
    assign dmem_wdata = mw_wdata;
    assign stall      = dmem_req && !dmem_ready;
    assign retire     = mw_valid && !stall;
    assign halted     = (state == ST_HALTED);

    // Value the MEM/WB instruction writes back; loads forward the live read data
    assign wb_val = (mw_op == OP_LW) ? dmem_rdata : mw_result;

    assign ex_op     = ifid_instr[15:12];
    assign ex_rd     = ASIZE'(ifid_instr[11:8]);
    assign ex_rs     = ASIZE'(ifid_instr[7:4]);
    assign ex_rt     = ASIZE'(ifid_instr[3:0]);
    assign ex_imm    = ifid_instr[IMMW-1:0];
    assign ex_imm_d  = DSIZE'($signed(ex_imm));
    assign br_target = ifid_pc + ISIZE'(1) + ISIZE'($signed(ex_imm));

    // Operand read with MEM/WB forwarding (R0 is never written, so it reads 0)
    always_comb begin
        val_rd = regs[ex_rd];
        val_rs = regs[ex_rs];
        val_rt = regs[ex_rt];
        if (mw_wr && mw_rd == ex_rd) val_rd = wb_val;
        if (mw_wr && mw_rd == ex_rs) val_rs = wb_val;
        if (mw_wr && mw_rd == ex_rt) val_rt = wb_val;
    end

    // ALU, address generation and branch resolution
    always_comb begin
        ex_result = '0;
        ex_wr     = 1'b0;
        ex_taken  = 1'b0;
        ex_halt   = 1'b0;
        case (ex_op)
            OP_ADD:  begin ex_result = val_rs + val_rt; ex_wr = 1'b1; end
            OP_SUB:  begin ex_result = val_rs - val_rt; ex_wr = 1'b1; end
            OP_AND:  begin ex_result = val_rs & val_rt; ex_wr = 1'b1; end
            OP_OR:   begin ex_result = val_rs | val_rt; ex_wr = 1'b1; end
            OP_SLT:  begin
                ex_result = DSIZE'($signed(val_rs) < $signed(val_rt));
                ex_wr     = 1'b1;
            end
            OP_ADDI: begin ex_result = val_rs + ex_imm_d; ex_wr = 1'b1; end
            OP_LW:   begin ex_result = val_rs + ex_imm_d; ex_wr = 1'b1; end
            OP_SW:   ex_result = val_rs + ex_imm_d;
            OP_BEQ:  ex_taken = ifid_valid && (val_rd == val_rs);
            OP_HALT: ex_halt = ifid_valid;
            default: ex_result = '0;
        endcase
    end

    // Halt sequencing state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // Halt sequencing next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:     if (ex_halt && !stall) state_nxt = ST_HALTING;
            ST_HALTING: if (mw_valid && mw_op == OP_HALT) state_nxt = ST_HALTED;
            ST_HALTED:  state_nxt = ST_HALTED;
            default:    state_nxt = ST_RUN;
        endcase
    end

    // Pipeline registers, PC and regfile; a stall freezes all of them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            mw_valid   <= 1'b0;
            mw_wr      <= 1'b0;
            mw_op      <= '0;
            mw_rd      <= '0;
            mw_result  <= '0;
            mw_wdata   <= '0;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (!stall) begin
            if (mw_wr) regs[mw_rd] <= wb_val;

            mw_valid  <= ifid_valid;
            mw_wr     <= ifid_valid && ex_wr && (ex_rd != '0);
            mw_op     <= ex_op;
            mw_rd     <= ex_rd;
            mw_result <= ex_result;
            mw_wdata  <= val_rd;

            if (ex_halt || state != ST_RUN) begin
                ifid_valid <= 1'b0;
            end else if (ex_taken) begin
                pc         <= br_target;
                ifid_valid <= 1'b0;
            end else begin
                ifid_valid <= 1'b1;
                ifid_instr <= imem_data;
                ifid_pc    <= pc;
                pc         <= pc + ISIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe3_core.sv
// tb_pipe3_core: directed and randomized checks of pipe3_core against an
// instruction-level reference model of the ISA.
module tb_pipe3_core;
    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ready = 1'b1;
    logic        halted;
    logic        retire;
    logic [15:0] pc;

    logic [7:0]  imem8_addr;
    logic [15:0] imem8_data;
    logic        dmem8_req;
    logic        dmem8_we;
    logic [7:0]  dmem8_addr;
    logic [7:0]  dmem8_wdata;
    logic [7:0]  dmem8_rdata;
    logic        dmem8_ready;
    logic        halted8;
    logic        retire8;
    logic [7:0]  pc8;

    logic [15:0] imem  [256];
    logic [15:0] imem8 [256];
    logic [15:0] dmem  [256];

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 0;
    int low_left = 3;

    int          cyc_halt;
    int          n_retire;
    int          n_stall;
    int          stall_bad;
    logic [15:0] pclog [$];
    logic [31:0] st_q  [$];

    logic [15:0] m_regs [16];
    logic [15:0] m_mem  [256];
    logic [31:0] m_st   [$];
    int          m_ret;

    pipe3_core dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .halted(halted), .retire(retire), .pc(pc)
    );

    pipe3_core #(.DSIZE(8), .ASIZE(4), .ISIZE(8), .IMMW(4)) dut8 (
        .clk(clk), .rst(rst),
        .imem_addr(imem8_addr), .imem_data(imem8_data),
        .dmem_req(dmem8_req), .dmem_we(dmem8_we), .dmem_addr(dmem8_addr),
        .dmem_wdata(dmem8_wdata), .dmem_rdata(dmem8_rdata), .dmem_ready(dmem8_ready),
        .halted(halted8), .retire(retire8), .pc(pc8)
    );

    assign imem_data   = imem[imem_addr[7:0]];
    assign dmem_rdata  = dmem[dmem_addr[7:0]];
    assign imem8_data  = imem8[imem8_addr];
    assign dmem8_rdata = 8'h00;
    assign dmem8_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data-memory ready: 0 = always ready, 1 = random, 2 = first request waits 3 cycles
    always @(posedge clk) begin
        #1;
        if (rst) begin
            dmem_ready = 1'b1;
            low_left   = 3;
        end else if (rdy_mode == 2) begin
            if (dmem_req && low_left != 0) begin
                dmem_ready = 1'b0;
                low_left   = low_left - 1;
            end else begin
                dmem_ready = 1'b1;
            end
        end else if (rdy_mode == 1) begin
            dmem_ready = ($urandom_range(0, 2) != 0);
        end else begin
            dmem_ready = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    // Runs from the negedge of reset release, sampling each cycle until halted
    task automatic run_prog(input int max_cyc);
        logic [15:0] frz_pc;
        logic        prev_stall;
        frz_pc     = '0;
        prev_stall = 1'b0;
        n_retire   = 0;
        n_stall    = 0;
        stall_bad  = 0;
        cyc_halt   = -1;
        pclog.delete();
        st_q.delete();
        for (int k = 0; k < max_cyc; k++) begin
            if (k > 0) @(negedge clk);
            if (pclog.size() == 0 || pclog[pclog.size()-1] != pc) pclog.push_back(pc);
            if (retire) n_retire++;
            if (dmem_req && !dmem_ready) begin
                if (!prev_stall) frz_pc = pc;
                else if (pc != frz_pc) stall_bad++;
                if (retire) stall_bad++;
                n_stall++;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (dmem_req && dmem_we && dmem_ready) begin
                st_q.push_back({dmem_addr, dmem_wdata});
                dmem[dmem_addr[7:0]] = dmem_wdata;
            end
            if (halted) begin
                cyc_halt = k;
                break;
            end
        end
        chk("halt_reached", 32'(cyc_halt >= 0), 32'd1);
    endtask

    // Sequential ISA execution of imem against m_mem
    task automatic model_run();
        logic [15:0] mpc, nxt, ins, imm, a, b, c, res, addr;
        logic [3:0]  op, d, s, t;
        logic        wr;
        mpc   = '0;
        m_ret = 0;
        m_st.delete();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        for (int step = 0; step < 2000; step++) begin
            ins  = imem[mpc[7:0]];
            op   = ins[15:12];
            d    = ins[11:8];
            s    = ins[7:4];
            t    = ins[3:0];
            imm  = {{12{ins[3]}}, ins[3:0]};
            a    = m_regs[s];
            b    = m_regs[t];
            c    = m_regs[d];
            nxt  = mpc + 16'd1;
            res  = '0;
            wr   = 1'b0;
            m_ret++;
            if (op == 4'hF) break;
            case (op)
                4'h0: begin res = a + b; wr = 1'b1; end
                4'h1: begin res = a - b; wr = 1'b1; end
                4'h2: begin res = a & b; wr = 1'b1; end
                4'h3: begin res = a | b; wr = 1'b1; end
                4'h4: begin res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0; wr = 1'b1; end
                4'h5: begin res = a + imm; wr = 1'b1; end
                4'h6: begin addr = a + imm; res = m_mem[addr[7:0]]; wr = 1'b1; end
                4'h7: begin
                    addr = a + imm;
                    m_mem[addr[7:0]] = c;
                    m_st.push_back({addr, c});
                end
                4'h8: if (c == a) nxt = mpc + 16'd1 + imm;
                default: ;
            endcase
            if (wr && d != 4'd0) m_regs[d] = res;
            mpc = nxt;
        end
    endtask

    initial begin
        logic [3:0]  op, rd, rs, imm;
        int          r;
        logic [7:0]  prev8;
        int          wraps;

        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            imem8[i] = 16'h9000;
            dmem[i]  = '0;
        end
        imem8[2] = 16'h510F;
        clear_imem();

        // Reset state
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);

        // Basic ALU sequence with forwarding
        imem[0] = 16'h5103; imem[1] = 16'h520E; imem[2] = 16'h0312; imem[3] = 16'hF000;
        do_reset();
        run_prog(40);
        chk("t1_r3", 32'(dut.regs[3]), 32'd1);
        chk("t1_retire", 32'(n_retire), 32'd4);
        chk("t1_halt_cyc", 32'(cyc_halt), 32'd6);
        repeat (3) @(negedge clk);
        chk("t1_halt_sticky", 32'(halted), 32'd1);
        chk("t1_pc_frozen", 32'(pc), 32'd4);
        chk("t1_no_retire", 32'(retire), 32'd0);

        // Store then load-use with no bubble
        clear_imem();
        imem[0] = 16'h5105; imem[1] = 16'h7102; imem[2] = 16'h6402; imem[3] = 16'h0544;
        do_reset();
        run_prog(40);
        chk("t2_nstores", 32'(st_q.size()), 32'd1);
        if (st_q.size() > 0) chk("t2_store", st_q[0], 32'h0002_0005);
        chk("t2_r5", 32'(dut.regs[5]), 32'd10);
        chk("t2_retire", 32'(n_retire), 32'd5);
        chk("t2_halt_cyc", 32'(cyc_halt), 32'd7);

        // Taken branch squashes one slot
        clear_imem();
        imem[0] = 16'h5101; imem[1] = 16'h8112; imem[2] = 16'h5607; imem[3] = 16'h5607;
        do_reset();
        run_prog(40);
        chk("t3_r6", 32'(dut.regs[6]), 32'd0);
        chk("t3_r1", 32'(dut.regs[1]), 32'd1);
        chk("t3_retire", 32'(n_retire), 32'd3);
        chk("t3_pclog_len", 32'(pclog.size() >= 4), 32'd1);
        if (pclog.size() >= 4) begin
            chk("t3_pc0", 32'(pclog[0]), 32'd0);
            chk("t3_pc1", 32'(pclog[1]), 32'd1);
            chk("t3_pc2", 32'(pclog[2]), 32'd2);
            chk("t3_pc3", 32'(pclog[3]), 32'd4);
        end

        // Reset asserted while a load is stalled
        clear_imem();
        imem[0] = 16'h6205; imem[1] = 16'h0322; imem[2] = 16'hF000;
        dmem[5] = 16'h1234;
        rdy_mode = 2;
        do_reset();
        repeat (2) @(negedge clk);
        chk("t4r_stalling", 32'({dmem_req, dmem_ready}), 32'b10);
        rst = 1'b1;
        #1;
        chk("t4r_req", 32'(dmem_req), 32'd0);
        chk("t4r_pc", 32'(pc), 32'd0);

        // Load with ready held low for three cycles
        do_reset();
        run_prog(60);
        chk("t4_nstall", 32'(n_stall), 32'd3);
        chk("t4_frozen", 32'(stall_bad), 32'd0);
        chk("t4_r2", 32'(dut.regs[2]), 32'h1234);
        chk("t4_r3", 32'(dut.regs[3]), 32'h2468);
        chk("t4_retire", 32'(n_retire), 32'd3);
        chk("t4_halt_cyc", 32'(cyc_halt), 32'd8);
        rdy_mode = 0;

        // Reset in the cycle after HALT enters EX, then restart
        clear_imem();
        imem[0] = 16'h5103; imem[1] = 16'h520E; imem[2] = 16'h0312; imem[3] = 16'hF000;
        do_reset();
        repeat (5) @(negedge clk);
        chk("t5_halt_retiring", 32'(retire), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_halted", 32'(halted), 32'd0);
        chk("t5_pc", 32'(pc), 32'd0);
        chk("t5_r3_cleared", 32'(dut.regs[3]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_prog(40);
        chk("t5_restart_r3", 32'(dut.regs[3]), 32'd1);
        chk("t5_restart_cyc", 32'(cyc_halt), 32'd6);

        // Random programs against the ISA model
        for (int p = 0; p < 10; p++) begin
            rdy_mode = (p % 2 == 1) ? 1 : 0;
            clear_imem();
            for (int i = 0; i < 24; i++) begin
                r  = int'($urandom_range(0, 11));
                op = 4'(r);
                if (r == 9)  op = 4'h9;
                if (r == 10) op = 4'h5;
                if (r == 11) op = 4'hC;
                rd  = 4'($urandom_range(0, 7));
                rs  = 4'($urandom_range(0, 7));
                imm = 4'($urandom_range(0, 15));
                if (op == 4'h8) imm = 4'($urandom_range(0, 7));
                imem[i] = {op, rd, rs, imm};
            end
            for (int i = 0; i < 256; i++) begin
                dmem[i]  = 16'($urandom);
                m_mem[i] = dmem[i];
            end
            model_run();
            do_reset();
            run_prog(400);
            chk("rnd_retire", 32'(n_retire), 32'(m_ret));
            chk("rnd_nstores", 32'(st_q.size()), 32'(m_st.size()));
            for (int i = 0; i < st_q.size() && i < m_st.size(); i++)
                chk("rnd_store", st_q[i], m_st[i]);
            for (int i = 1; i < 16; i++)
                chk("rnd_reg", 32'(dut.regs[i]), 32'(m_regs[i]));
        end
        rdy_mode = 0;

        // Narrow core: PC wraps 0xFF -> 0x00, ADDI -1 gives 0xFF
        do_reset();
        wraps = 0;
        prev8 = pc8;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (prev8 == 8'hFF) begin
                chk("w8_pc_wrap", 32'(pc8), 32'd0);
                wraps++;
            end
            prev8 = pc8;
        end
        chk("w8_wraps", 32'(wraps), 32'd1);
        chk("w8_r1", 32'(dut8.regs[1]), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe3_core.md
# pipe3_core

Parameterised three-stage pipelined core (IF, EX, MEM/WB) that succeeds the single-cycle datapath. It executes the same 16-bit, 4-bit-opcode ISA, with data width, register count and PC width set by parameters. It adds EX-stage forwarding, a one-bubble branch flush, a stall handshake on data memory, and a HALT state. Instruction and data memories are external and attach to its ports.

## Interface
- DSIZE, 16: data and register width.
- ASIZE, 4: register index width; the core has 2^ASIZE registers.
- ISIZE, 16: PC and instruction-address width.
- IMMW, 4: immediate width, sign-extended to DSIZE or ISIZE as needed.
- clk  in  1  the single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ISIZE  fetch address, equal to the PC.
- imem_data  in  16  instruction word, combinational read of imem_addr.
- dmem_req  out  1  MEM/WB stage holds a valid LW or SW.
- dmem_we  out  1  1 = store.
- dmem_addr  out  DSIZE  effective address.
- dmem_wdata  out  DSIZE  store data.
- dmem_rdata  in  DSIZE  load data, valid when dmem_ready=1.
- dmem_ready  in  1  access completes this cycle.
- halted  out  1  HALT has retired; the core is frozen.
- retire  out  1  pulses for 1 cycle per instruction leaving MEM/WB.
- pc  out  ISIZE  current fetch PC (debug).

## Operation
- Instruction format: op[15:12], rd[11:8], rs[7:4], rt/imm[3:0]. Register fields are ASIZE wide and zero-extended; R0 always reads 0 and writes to it are dropped.
- Opcodes:
  - 0 ADD: rd=rs+rt.
  - 1 SUB: rd=rs-rt.
  - 2 AND, 3 OR.
  - 4 SLT: signed compare, result 1/0.
  - 5 ADDI: rd=rs+sext(imm).
  - 6 LW: rd=M[rs+sext(imm)].
  - 7 SW: M[rs+sext(imm)]=rd.
  - 8 BEQ: if R[rd]==R[rs], PC = branch_PC+1+sext(imm).
  - F HALT.
  - All other opcodes are NOPs.
- Arithmetic is modulo 2^DSIZE. PC arithmetic is modulo 2^ISIZE; PC wrap from all-ones to 0 is legal.
- IF: latches imem_data and PC into the IF/ID register with a valid bit.
- EX: decodes, reads the regfile, forwards, executes the ALU and resolves branches. Results go into the MEM/WB register with a valid bit.
- Forwarding: if the MEM/WB instruction is valid, writes rd≠0, and its rd matches an EX source, the EX stage uses the MEM/WB value instead of the regfile. For LW that value is dmem_rdata; for ALU ops it is the ALU result. This makes load-use run with no bubble.
- Branch taken in EX:
  - PC loads the target.
  - The IF/ID valid bit clears (one squashed slot).
  - Not-taken costs nothing.
- MEM/WB:
  - LW/SW raise dmem_req.
  - The regfile is written at the edge that ends the stage, unless the pipeline is stalled.
- Stall condition: dmem_req=1 and dmem_ready=0. While stalled:
  - PC, IF/ID, MEM/WB and the regfile all hold.
  - No write occurs and retire stays 0.
- HALT in EX:
  - The PC freezes.
  - IF/ID is invalidated.
  - Later fetches are ignored.
  - When HALT retires, halted rises and stays set until rst.
- States: RUN, HALTING (HALT in MEM/WB), HALTED.

## Timing
- Reset values: PC=0, all valid bits 0, all registers 0, halted=0, retire=0, dmem_req=0, dmem_we=0.
- While rst is asserted the core must not issue any dmem_req.
- An instruction fetched in cycle n is in EX at n+1 and MEM/WB at n+2; its result is visible in the regfile from n+3.
- Branch penalty is 1 cycle when taken.
- dmem_ready is sampled at the edge. A single-cycle access (ready=1 on the same cycle as the request) causes no stall.
- Simultaneous taken branch and stall: the stall wins. The branch completes on the first non-stalled edge.
- Reset asserted mid-stall or mid-halt returns to the reset values immediately (asynchronous).
- HALT preceded by a stalled SW: halted rises only after the SW completes and HALT retires.

## Test plan
- ADDI R1,R0,3; ADDI R2,R0,-2; ADD R3,R1,R2; HALT -> R3=1, 4 retire pulses, halted=1 by cycle 6.
- ADDI R1,R0,5; SW R1,[R0+2]; LW R4,[R0+2]; ADD R5,R4,R4 -> dmem write addr 2 data 5, R5=10, no bubble.
- ADDI R1,R0,1; BEQ R1,R1,+2; ADDI R6,R0,7; ADDI R6,R0,7; HALT -> R6=0. The slot after BEQ is squashed, so the skipped instructions do not retire; PC sequence 0,1,2,4.
- LW with dmem_ready held low for 3 cycles -> PC and retire frozen for exactly 3 cycles, then the load completes with the correct data.
- rst asserted in the cycle after HALT enters EX -> halted=0, PC=0, and execution restarts from address 0.
- DSIZE=8, ISIZE=8: PC runs from 0xFF to 0x00 with NOPs, and ADDI R1,R0,-1 gives R1=0xFF.
